// File: rtl/audio_out_i2s.sv
// I2S output stage: buffers 24-bit mixed samples in a small FIFO and serialises
// each one on both channels of a 64-BCLK frame, with sticky under/overflow flags.
module audio_out_i2s #(
    parameter int CLK_DIV = 4,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [23:0]        i_data,
    input  logic               i_valid,
    output logic               o_bclk,
    output logic               o_lrck,
    output logic               o_dacdat,
    output logic [FIFO_AW:0]   o_level,
    output logic               o_underflow,
    output logic               o_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]      div_cnt;
    logic [5:0]         bit_cnt;
    logic [23:0]        shadow;
    logic [23:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic               div_wrap;
    logic               fall;
    logic               frame_start;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic [5:0]         bit_next;
    logic [4:0]         slot;
    logic [4:0]         bit_idx;
    logic [23:0]        shadow_next;
    logic               ser_bit;

    always_comb begin
        div_wrap    = (div_cnt == DW'(CLK_DIV - 1));
        fall        = div_wrap && o_bclk;
        bit_next    = bit_cnt + 6'd1;
        frame_start = fall && (bit_next == 6'd0);
        empty       = (count == '0);
        full        = (count == (FIFO_AW+1)'(DEPTH));
        pop         = frame_start && !empty;
        // A pop frees a slot this same edge, so a full FIFO still accepts then.
        push        = i_valid && (!full || pop);
        shadow_next = pop ? mem[rd_ptr] : shadow;
        slot        = bit_next[4:0];
        bit_idx     = 5'd24 - slot;
        ser_bit     = 1'b0;
        // One-BCLK I2S delay: MSB lands at slot 1, slots 25..31 are padding.
        if (slot >= 5'd1 && slot <= 5'd24) begin
            ser_bit = shadow_next[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            o_bclk      <= 1'b0;
            bit_cnt     <= '1;
            o_lrck      <= 1'b0;
            o_dacdat    <= 1'b0;
            shadow      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                o_bclk  <= ~o_bclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (fall) begin
                bit_cnt  <= bit_next;
                o_lrck   <= bit_next[5];
                o_dacdat <= ser_bit;
                shadow   <= shadow_next;
            end

            if (frame_start && empty) begin
                o_underflow <= 1'b1;
            end
            if (i_valid && !push) begin
                o_overflow <= 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_level = count;

endmodule

// File: tb/tb_audio_out_i2s.sv
// Bench for audio_out_i2s: per-cycle comparison against a frame-timing model
// derived from the edge count, plus tabled sample/serial-word vectors.
module tb_audio_out_i2s;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [23:0]      i_data = '0;
    logic             i_valid = 1'b0;
    logic             o_bclk;
    logic             o_lrck;
    logic             o_dacdat;
    logic [FIFO_AW:0] o_level;
    logic             o_underflow;
    logic             o_overflow;

    audio_out_i2s #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_bclk(o_bclk), .o_lrck(o_lrck), .o_dacdat(o_dacdat),
        .o_level(o_level), .o_underflow(o_underflow), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: everything follows from edges since reset release.
    int          mk;
    logic [23:0] mq[$];
    logic [23:0] msh;
    logic        mund, movf, mbclk, mlrck, mdat;
    int          mb;
    logic        m_fall, m_fs;
    int          first_fall;
    logic        prev_bclk;

    typedef struct {
        logic [23:0] sample;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mk = 0; mq.delete(); msh = '0; mund = 0; movf = 0;
        mbclk = 0; mlrck = 0; mdat = 0; mb = 63; m_fall = 0; m_fs = 0;
        first_fall = 0; prev_bclk = 0;
    endtask

    task automatic model_step(input logic v, input logic [23:0] d);
        int h, s;
        mk++;
        h = mk / CLK_DIV;
        mbclk  = h[0];
        m_fall = (mk % CLK_DIV == 0) && (h % 2 == 0);
        m_fs   = 0;
        if (m_fall) begin
            mb   = (63 + h / 2) % 64;
            m_fs = (mb == 0);
        end
        if (m_fs) begin
            if (mq.size() > 0) msh = mq.pop_front();
            else mund = 1;
        end
        if (v) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else movf = 1;
        end
        if (m_fall) begin
            s = mb % 32;
            mlrck = (mb >= 32);
            mdat  = (s >= 1 && s <= 24) ? msh[24 - s] : 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("bclk", 32'(o_bclk), 32'(mbclk));
        chk("lrck", 32'(o_lrck), 32'(mlrck));
        chk("dacdat", 32'(o_dacdat), 32'(mdat));
        chk("level", 32'(o_level), 32'(mq.size()));
        chk("underflow", 32'(o_underflow), 32'(mund));
        chk("overflow", 32'(o_overflow), 32'(movf));
    endtask

    task automatic tick(input logic v, input logic [23:0] d);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else begin
            model_step(v, d);
            if (prev_bclk && !o_bclk && first_fall == 0) first_fall = mk;
            prev_bclk = o_bclk;
        end
        compare_all();
    endtask

    task automatic run_frame(output logic [63:0] bits);
        int guard;
        bits = '0;
        guard = 0;
        do begin
            tick(1'b0, '0);
            guard++;
        end while (!m_fs && guard < 2000);
        chk("frame_start_timeout", 32'(m_fs), 32'd1);
        bits[63] = o_dacdat;
        guard = 0;
        do begin
            tick(1'b0, '0);
            if (m_fall) bits[63 - mb] = o_dacdat;
            guard++;
        end while (!(m_fall && mb == 63) && guard < 2000);
    endtask

    task automatic reset_and_release(input int hold);
        rst = 1'b0;
        for (int i = 0; i < hold; i++) tick(i[0], 24'($urandom));
        chk("rst_bclk", 32'(o_bclk), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        rst = 1'b1;
    endtask

    logic [63:0] bits;
    logic [23:0] rnd;

    initial begin
        vecs[0] = '{24'hA5C3F1, 32'h52E1F880};
        vecs[1] = '{24'h800000, 32'h40000000};
        vecs[2] = '{24'h000001, 32'h00000080};
        vecs[3] = '{24'hFFFFFF, 32'h7FFFFF80};
        vecs[4] = '{24'hA5C3F1, 32'h52E1F880};
        model_reset();

        #1 reset_and_release(5);

        // Tabled samples: one push ahead of each frame, both halves identical.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, vecs[i].sample);
            run_frame(bits);
            chk($sformatf("frame_vec%0d", i), 32'(bits[63:32] == {vecs[i].word}) , 32'd1);
            chk($sformatf("frame_vec%0d_right", i), bits[31:0], vecs[i].word);
            if (i == 0) chk("first_fall_edge", 32'(first_fall), 32'(2 * CLK_DIV));
        end
        chk("no_underflow_yet", 32'(o_underflow), 32'd0);

        // Empty FIFO at frame start repeats the last sample.
        run_frame(bits);
        chk("underflow_repeat", bits[63:32], 32'h52E1F880);
        chk("underflow_repeat_r", bits[31:0], 32'h52E1F880);
        chk("underflow_flag", 32'(o_underflow), 32'd1);

        // Burst of 6 with no frame start between: last two are dropped.
        for (int n = 1; n <= 6; n++) tick(1'b1, 24'(n));
        chk("ovf_level", 32'(o_level), 32'd4);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        for (int n = 1; n <= 4; n++) begin
            run_frame(bits);
            chk($sformatf("ovf_frame%0d", n), bits[63:32], 32'(n) << 7);
        end

        // Random samples against the model.
        for (int i = 0; i < 3; i++) begin
            rnd = 24'($urandom);
            tick(1'b1, rnd);
            run_frame(bits);
            chk($sformatf("rand_frame%0d", i), bits[63:32], {1'b0, rnd, 7'd0});
        end

        // Asynchronous reset at b=12 clears outputs without a clock edge.
        for (int g = 0; g < 2000 && !(m_fall && mb == 12); g++) tick(1'b0, '0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_bclk", 32'(o_bclk), 32'd0);
        chk("midrst_lrck", 32'(o_lrck), 32'd0);
        chk("midrst_dacdat", 32'(o_dacdat), 32'd0);
        chk("midrst_flags", {30'd0, o_underflow, o_overflow}, 32'd0);
        reset_and_release(3);

        // Fill to full, then push exactly on the first frame-start edge.
        for (int n = 1; n <= 4; n++) tick(1'b1, 24'(n + 16));
        while (mk < 2 * CLK_DIV - 1) tick(1'b0, '0);
        tick(1'b1, 24'h000015);
        chk("restart_first_fall", 32'(first_fall), 32'(2 * CLK_DIV));
        chk("fullpop_fs", 32'(m_fs), 32'd1);
        chk("fullpop_level", 32'(o_level), 32'd4);
        chk("fullpop_ovf", 32'(o_overflow), 32'd0);
        run_frame(bits);
        chk("fullpop_next", bits[63:32], 32'(18) << 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
